// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, default
// parameter values and the branch-target helper.
package if_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam int          DEF_PC_STEP   = 4;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

  // br_offset is a word offset; the sum wraps silently at 32 bits.
  function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                input logic [31:0] offset);
    return pc4 + (offset << 2);
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: load a new slot, flush it to a NOP bubble, or hold.
// Flushing keeps pc4 so the register contents stay deterministic.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc4,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr <= NOP_INSTR;
      pc4   <= 32'h0;
      valid <= 1'b0;
    end else if (load) begin
      instr <= load_instr;
      pc4   <= load_pc4;
      valid <= 1'b1;
    end else if (flush) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, runs a req/ack fetch port with a
// one-deep skid buffer for frozen cycles, and feeds the IF/ID register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter int          PC_STEP   = DEF_PC_STEP,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        freeze,
  input  logic        br_taken,
  input  logic [31:0] br_offset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  state_t      state;
  logic [31:0] pc;
  logic        kill;
  logic [31:0] kill_addr;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc4;

  logic        redir;
  logic [31:0] target;
  logic        idr_load;
  logic        idr_flush;
  logic [31:0] idr_instr;
  logic [31:0] idr_pc4;

  assign redir  = br_taken & ~freeze;
  assign target = branch_target(if_id_pc4, br_offset);

  // While a killed request is outstanding the port keeps its original address
  // even though pc already points at the branch target.
  assign imem_req  = (state == ST_REQ);
  assign imem_addr = kill ? kill_addr : pc;

  always_comb begin
    idr_load  = 1'b0;
    idr_flush = 1'b0;
    idr_instr = imem_rdata;
    idr_pc4   = pc + STEP;
    case (state)
      ST_REQ: begin
        if (!freeze) begin
          if (imem_ack && !kill && !br_taken) idr_load  = 1'b1;
          else                                idr_flush = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!freeze) begin
          if (br_taken) begin
            idr_flush = 1'b1;
          end else begin
            idr_load  = 1'b1;
            idr_instr = skid_instr;
            idr_pc4   = skid_pc4;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      kill       <= 1'b0;
      kill_addr  <= 32'h0;
      skid_instr <= NOP_INSTR;
      skid_pc4   <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_REQ;
        end
        ST_REQ: begin
          if (imem_ack && kill) begin
            kill <= 1'b0;
            if (redir) pc <= target;
          end else if (imem_ack && redir) begin
            pc <= target;
          end else if (imem_ack && freeze) begin
            skid_instr <= imem_rdata;
            skid_pc4   <= pc + STEP;
            state      <= ST_HOLD;
          end else if (imem_ack) begin
            pc <= pc + STEP;
          end else if (redir) begin
            kill_addr <= imem_addr;
            kill      <= 1'b1;
            pc        <= target;
          end
        end
        ST_HOLD: begin
          if (!freeze) begin
            state <= ST_REQ;
            pc    <= br_taken ? target : pc + STEP;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (idr_load),
    .flush      (idr_flush),
    .load_instr (idr_instr),
    .load_pc4   (idr_pc4),
    .instr      (if_id_instr),
    .pc4        (if_id_pc4),
    .valid      (if_id_valid)
  );

endmodule
